// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state enumeration and cycle-count helpers for host transmitter and receiver
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, DONE} ps2_state_t;
  function automatic int cycles_us(input int hz, input int us);
    return int'(longint'(hz) * longint'(us) / 64'sd1000000);
  endfunction
  function automatic int cycles_ms(input int hz, input int ms);
    return int'(longint'(hz) * longint'(ms) / 64'sd1000);
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronisers for ps2 clk/data (reset to idle-high) plus ps2 clk falling-edge strobe; ports clk, reset(async low), ps2_clk_in, ps2_data_in -> clk_s, data_s, fall
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);
  logic [1:0] c_ff, d_ff;
  logic c_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      c_ff <= 2'b11;
      d_ff <= 2'b11;
      c_d <= 1'b1;
    end else begin
      c_ff <= {c_ff[0], ps2_clk_in};
      d_ff <= {d_ff[0], ps2_data_in};
      c_d <= c_ff[1];
    end
  assign clk_s = c_ff[1];
  assign data_s = d_ff[1];
  assign fall = c_d & ~c_ff[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte sender (inhibit, request, 11-bit frame, ack check); ports clk, reset(async low), tx_data/tx_valid/tx_ready, ps2_clk_in/ps2_data_in, ps2_clk_oe/ps2_data_oe (1 pulls low), tx_done/tx_ack_err/tx_timeout; watchdog enabled by PS2_HOST_TX_TIMEOUT_EN
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 3250000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);
  localparam int IC = cycles_us(CLK_FREQ_HZ, INHIBIT_US);
  localparam int CW = $clog2(IC + 1);
  ps2_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] n, n_n;
  logic [8:0] sh, sh_n;
  logic dq, dq_n, ack_err, ack_err_n;
  logic clk_s, data_s, fall, expire;
  ps2_sync_edge u_sync (
    .clk(clk),
    .reset(reset),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_s(clk_s),
    .data_s(data_s),
    .fall(fall)
  );
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TC = cycles_ms(CLK_FREQ_HZ, TIMEOUT_MS);
  localparam int TW = $clog2(TC + 1);
  logic [TW-1:0] wd;
  logic to;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wd <= '0;
      to <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      wd <= '0;
      to <= 1'b0;
    end else if (expire) to <= 1'b1;
    else if (state != IDLE && state != DONE) wd <= wd + 1'b1;
  assign expire = state != IDLE && state != DONE && wd == TW'(TC - 1);
  assign tx_timeout = to;
`else
  assign expire = 1'b0;
  assign tx_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      sh <= '0;
      dq <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      n <= n_n;
      sh <= sh_n;
      dq <= dq_n;
      ack_err <= ack_err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    n_n = n;
    sh_n = sh;
    dq_n = dq;
    ack_err_n = ack_err;
    case (state)
      IDLE: if (tx_valid) begin
        state_n = INHIBIT;
        cnt_n = '0;
        sh_n = {~^tx_data, tx_data};
        ack_err_n = 1'b0;
      end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        state_n = cnt == CW'(IC - 1) ? REQ : INHIBIT;
      end
      REQ: begin
        state_n = SEND;
        dq_n = 1'b1;
        n_n = '0;
      end
      SEND: if (fall) begin
        n_n = n + 4'd1;
        dq_n = (n != 4'd9) & ~sh[0];
        sh_n = sh >> 1;
        state_n = n == 4'd9 ? ACK : SEND;
      end
      ACK: if (fall) begin
        ack_err_n = data_s;
        state_n = RELEASE;
      end
      RELEASE: state_n = clk_s && data_s ? DONE : RELEASE;
      default: state_n = IDLE;
    endcase
    if (expire) state_n = DONE;
  end
  assign tx_ready = state == IDLE;
  assign ps2_clk_oe = state == INHIBIT;
  assign ps2_data_oe = state == REQ || (state == INHIBIT && cnt == CW'(IC - 1)) || (state == SEND && dq);
  assign tx_done = state == DONE;
  assign tx_ack_err = ack_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench with a PS/2 device model, vector table and frame scoreboard
module tb_ps2_host_tx;
  logic clk = 1'b0, reset = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_ack_err, tx_timeout;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  wire ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  wire ps2_data_in = ~(ps2_data_oe | dev_data_low);
  localparam int H = 20;
  int checks = 0, errors = 0, acc_cnt = 0;
  typedef struct {logic [10:0] frame; logic err; logic to;} exp_t;
  typedef struct {logic [7:0] d; bit ack; bit par; bit err;} vec_t;
  exp_t sb[$];
  vec_t vecs[7];
  always #5 clk = ~clk;
  ps2_host_tx dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done(tx_done),
    .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout)
  );
  always @(posedge clk) if (reset && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic wait_inhibit(output int ic, output int ov);
    int t = 0;
    bit seen = 0;
    ic = 0;
    ov = 0;
    while (t < 2000 && !(seen && !ps2_clk_oe)) begin
      @(negedge clk);
      t++;
      if (ps2_clk_oe) begin
        seen = 1;
        ic++;
      end
      if (ps2_clk_oe && ps2_data_oe) ov++;
    end
    check("inhibit_end_seen", {31'd0, seen && !ps2_clk_oe}, 1);
  endtask
  task automatic device(input int nf, input bit ack_low, output logic [10:0] fr);
    fr = '0;
    repeat (H) @(negedge clk);
    fr[0] = ps2_data_in;
    for (int k = 1; k <= nf; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      fr[k] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    if (nf == 10) begin
      dev_data_low = ack_low;
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
    end
  endtask
  task automatic finish_xfer(input logic [10:0] fr, input bit keep);
    int t = 0;
    exp_t e;
    while (!tx_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {31'd0, tx_done}, 1);
    if (!keep) tx_valid = 1'b0;
    check("sb_nonempty", {31'd0, sb.size() != 0}, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("frame", {21'd0, fr}, {21'd0, e.frame});
      check("ack_err", {31'd0, tx_ack_err}, {31'd0, e.err});
      check("timeout", {31'd0, tx_timeout}, {31'd0, e.to});
    end
    @(negedge clk);
    check("done_pulse", {31'd0, tx_done}, 0);
    check("ready_after", {31'd0, tx_ready}, 1);
  endtask
  task automatic run_vec(input vec_t v);
    int ic, ov;
    logic [10:0] fr;
    sb.push_back('{frame: {1'b1, v.par, v.d, 1'b0}, err: v.err, to: 1'b0});
    @(negedge clk);
    tx_data = v.d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check("ready_low", {31'd0, tx_ready}, 0);
    wait_inhibit(ic, ov);
    check("inhibit_cycles", ic, 325);
    check("inhibit_data_overlap", ov, 1);
    device(10, v.ack, fr);
    finish_xfer(fr, 1'b0);
  endtask
  initial begin
    int ic, ov, acc0, t;
    logic [10:0] fr;
    vecs[0] = '{d: 8'hED, ack: 1, par: 1, err: 0};
    vecs[1] = '{d: 8'h07, ack: 1, par: 0, err: 0};
    vecs[2] = '{d: 8'hFF, ack: 1, par: 1, err: 0};
    vecs[3] = '{d: 8'h00, ack: 0, par: 1, err: 1};
    vecs[4] = '{d: 8'h55, ack: 1, par: 1, err: 0};
    vecs[5] = '{d: 8'h80, ack: 0, par: 0, err: 1};
    vecs[6] = '{d: 8'h01, ack: 1, par: 0, err: 0};
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, tx_ready}, 1);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 0);
    check("rst_done", {31'd0, tx_done}, 0);
    check("rst_ack_err", {31'd0, tx_ack_err}, 0);
    check("rst_timeout", {31'd0, tx_timeout}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    foreach (vecs[i]) run_vec(vecs[i]);
    @(negedge clk);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_inhibit(ic, ov);
    device(5, 1'b0, fr);
    repeat (5) @(negedge clk);
    check("abort_pre_data_oe", {31'd0, ps2_data_oe}, 1);
    reset = 1'b0;
    #1;
    check("abort_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("abort_data_oe", {31'd0, ps2_data_oe}, 0);
    check("abort_ready", {31'd0, tx_ready}, 1);
    check("abort_ack_err", {31'd0, tx_ack_err}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_vec('{d: 8'hF4, ack: 1, par: 0, err: 0});
    acc0 = acc_cnt;
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{frame: {1'b1, 1'b1, 8'h3C, 1'b0}, err: 1'b0, to: 1'b0});
      wait_inhibit(ic, ov);
      check("hold_inhibit_cycles", ic, 325);
      device(10, 1'b1, fr);
      finish_xfer(fr, k == 0);
    end
    repeat (3) @(negedge clk);
    check("hold_accepts", acc_cnt - acc0, 2);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    @(negedge clk);
    tx_data = 8'h12;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    t = 0;
    while (!tx_done && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check("to_done_seen", {31'd0, tx_done}, 1);
    check("to_latency_ok", {31'd0, t >= 48749 && t <= 48753}, 1);
    check("to_flag", {31'd0, tx_timeout}, 1);
    check("to_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("to_data_oe", {31'd0, ps2_data_oe}, 0);
    @(negedge clk);
    check("to_ready", {31'd0, tx_ready}, 1);
    check("to_held", {31'd0, tx_timeout}, 1);
`endif
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
